// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with redirect, stall and misaligned-target trap.
//
// Purpose:
//   Issues one instruction-memory read per cycle at a sequential PC and presents
//   the returned word to decode one cycle later together with its PC. A redirect
//   (jalr or branch/jal) squashes the word in flight and restarts fetch at the
//   effective target. A stall freezes everything decode sees. A misaligned
//   effective target traps the unit until reset.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   pc_ctrl     in   2   00/01 sequential, 10 jalr target, 11 branch/jal target
//   target      in  32   redirect address, used when pc_ctrl[1]=1
//   stall       in   1   freeze fetch and decode-side outputs
//   imem_addr   out 32   fetch address for this cycle
//   imem_en     out  1   instruction memory read enable
//   imem_rdata  in  32   read data, one cycle after imem_en
//   inst        out 32   instruction to decode (NOP_INST when not valid)
//   inst_pc     out 32   PC of inst
//   inst_valid  out  1   inst is a real fetched instruction
//   fetch_fault out  1   sticky misaligned-target fault
//   fault_pc    out 32   offending effective target
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_ctrl,
  input  logic [31:0] target,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;           // address being fetched this cycle
  logic [31:0] ipc_q, ipc_d;         // PC of the word returning this cycle
  logic [31:0] hold_q, hold_d;       // word captured while decode is stalled
  logic        hold_vld_q, hold_vld_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic [31:0] eff_target;
  logic        redirect;

  // jalr targets drop bit 0; branch/jal targets are used as given.
  assign eff_target = pc_ctrl[0] ? target : {target[31:1], 1'b0};
  assign redirect   = pc_ctrl[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      ipc_q      <= 32'h0;
      hold_q     <= 32'h0;
      hold_vld_q <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ipc_d      = ipc_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    unique case (state_q)
      BOOT: begin
        if (!stall) begin
          state_d = RUN;
          ipc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
        end
      end
      RUN, FLUSH: begin
        if (redirect) begin
          // Redirect beats stall; any held word belongs to the old path.
          hold_vld_d = 1'b0;
          if (eff_target[1:0] != 2'b00) begin
            state_d    = TRAP;
            fault_d    = 1'b1;
            fault_pc_d = eff_target;
          end else begin
            state_d = FLUSH;
            pc_d    = eff_target;
          end
        end else if (stall) begin
          // The word arriving now is not consumed and its fetch is not
          // repeated, so keep it until the stall drops.
          if (state_q == RUN && !hold_vld_q) begin
            hold_d     = imem_rdata;
            hold_vld_d = 1'b1;
          end
        end else begin
          state_d    = RUN;
          ipc_d      = pc_q;
          pc_d       = pc_q + 32'd4;   // wraps modulo 2^32
          hold_vld_d = 1'b0;
        end
      end
      TRAP: begin
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_en    = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      BOOT:    imem_en = 1'b1;
      FLUSH:   imem_en = 1'b1;
      RUN: begin
        imem_en    = !stall;
        inst_valid = 1'b1;
      end
      default: imem_en = 1'b0;
    endcase
    // While reset is held the state already reads BOOT; keep the memory idle.
    imem_en = imem_en & rst_n;
  end

  assign imem_addr   = pc_q;
  assign inst        = inst_valid ? (hold_vld_q ? hold_q : imem_rdata) : NOP_INST;
  assign inst_pc     = ipc_q;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_ctrl;
  logic [31:0] target;
  logic        stall;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_ctrl    (pc_ctrl),
    .target     (target),
    .stall      (stall),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .fetch_fault(fetch_fault),
    .fault_pc   (fault_pc)
  );

  // Memory contents are a fixed function of the address; reads without
  // enable return garbage so a lost or stale word is visible.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction

  always @(posedge clk) imem_rdata <= imem_en ? memf(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  ctrl;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        en;
    logic        valid;
    logic [31:0] ipc;
    logic        fault;
    logic [31:0] fpc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [1:0] c, input logic [31:0] t,
                     input logic [31:0] a, input logic e, input logic v, input logic [31:0] p,
                     input logic f, input logic [31:0] fp);
    vec_t x;
    x.rst = r; x.stall = s; x.ctrl = c; x.tgt = t; x.addr = a; x.en = e;
    x.valid = v; x.ipc = p; x.fault = f; x.fpc = fp;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    @(negedge clk);
    if (t.rst) begin
      rst_n = 1'b0; stall = 1'b0; pc_ctrl = 2'b00; target = 32'h0;
    end else begin
      rst_n = 1'b1; stall = t.stall; pc_ctrl = t.ctrl; target = t.tgt;
    end
    #1;
    chk($sformatf("v%0d imem_addr", idx), imem_addr, t.addr);
    chk($sformatf("v%0d imem_en", idx), {31'b0, imem_en}, {31'b0, t.en});
    chk($sformatf("v%0d inst_valid", idx), {31'b0, inst_valid}, {31'b0, t.valid});
    chk($sformatf("v%0d inst", idx), inst, t.valid ? memf(t.ipc) : NOP);
    if (t.valid || t.rst) chk($sformatf("v%0d inst_pc", idx), inst_pc, t.ipc);
    chk($sformatf("v%0d fetch_fault", idx), {31'b0, fetch_fault}, {31'b0, t.fault});
    chk($sformatf("v%0d fault_pc", idx), fault_pc, t.fpc);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_ctrl = 2'b00; target = 32'h0;

    //   rst stall ctrl  target          addr            en valid ipc             flt fpc
    add(1, 0, 2'b00, 32'h0,         32'h0000_2000, 0, 0, 32'h0,         0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_2000, 1, 0, 32'h0,         0, 32'h0); // BOOT
    add(0, 0, 2'b00, 32'h0,         32'h0000_2004, 1, 1, 32'h0000_2000, 0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_2008, 1, 1, 32'h0000_2004, 0, 32'h0);
    add(0, 1, 2'b00, 32'h0,         32'h0000_200C, 0, 1, 32'h0000_2008, 0, 32'h0); // stall x3
    add(0, 1, 2'b00, 32'h0,         32'h0000_200C, 0, 1, 32'h0000_2008, 0, 32'h0);
    add(0, 1, 2'b00, 32'h0,         32'h0000_200C, 0, 1, 32'h0000_2008, 0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_200C, 1, 1, 32'h0000_2008, 0, 32'h0); // release
    add(0, 0, 2'b00, 32'h0,         32'h0000_2010, 1, 1, 32'h0000_200C, 0, 32'h0);
    add(0, 0, 2'b11, 32'h0000_2100, 32'h0000_2014, 1, 1, 32'h0000_2010, 0, 32'h0); // branch
    add(0, 0, 2'b00, 32'h0,         32'h0000_2100, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_2104, 1, 1, 32'h0000_2100, 0, 32'h0);
    add(0, 0, 2'b10, 32'h0000_2201, 32'h0000_2108, 1, 1, 32'h0000_2104, 0, 32'h0); // jalr odd
    add(0, 0, 2'b00, 32'h0,         32'h0000_2200, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_2204, 1, 1, 32'h0000_2200, 0, 32'h0);
    add(0, 1, 2'b11, 32'h0000_2300, 32'h0000_2208, 0, 1, 32'h0000_2204, 0, 32'h0); // redirect+stall
    add(0, 1, 2'b11, 32'h0000_2400, 32'h0000_2300, 1, 0, 32'h0,         0, 32'h0); // redirect in FLUSH
    add(0, 1, 2'b00, 32'h0,         32'h0000_2400, 1, 0, 32'h0,         0, 32'h0); // FLUSH stalled
    add(0, 0, 2'b00, 32'h0,         32'h0000_2400, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_2404, 1, 1, 32'h0000_2400, 0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_2408, 1, 1, 32'h0000_2404, 0, 32'h0);
    add(0, 0, 2'b11, 32'h0000_2202, 32'h0000_240C, 1, 1, 32'h0000_2408, 0, 32'h0); // misaligned
    add(0, 0, 2'b00, 32'h0,         32'h0000_240C, 0, 0, 32'h0,         1, 32'h0000_2202);
    add(0, 1, 2'b11, 32'h0000_3000, 32'h0000_240C, 0, 0, 32'h0,         1, 32'h0000_2202);
    add(0, 0, 2'b00, 32'h0,         32'h0000_240C, 0, 0, 32'h0,         1, 32'h0000_2202);
    add(1, 0, 2'b00, 32'h0,         32'h0000_2000, 0, 0, 32'h0,         0, 32'h0);     // reset in TRAP
    add(0, 0, 2'b00, 32'h0,         32'h0000_2000, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_2004, 1, 1, 32'h0000_2000, 0, 32'h0);
    add(0, 0, 2'b11, 32'hFFFF_FFF8, 32'h0000_2008, 1, 1, 32'h0000_2004, 0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'hFFFF_FFF8, 1, 0, 32'h0,         0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFF8, 0, 32'h0);
    add(0, 0, 2'b00, 32'h0,         32'h0000_0000, 1, 1, 32'hFFFF_FFFC, 0, 32'h0); // wrap
    add(0, 0, 2'b00, 32'h0,         32'h0000_0004, 1, 1, 32'h0000_0000, 0, 32'h0);

    repeat (2) @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Stall, then assert reset mid-cycle: the held word must be discarded.
    @(negedge clk);
    stall = 1'b1; #1;
    chk("stall0 inst_pc", inst_pc, 32'h0000_0004);
    chk("stall0 inst", inst, memf(32'h0000_0004));
    @(negedge clk); #1;
    chk("stall1 inst_held", inst, memf(32'h0000_0004));
    chk("stall1 imem_en", {31'b0, imem_en}, 32'h0);
    #2 rst_n = 1'b0; #1;
    chk("async_rst imem_addr", imem_addr, 32'h0000_2000);
    chk("async_rst imem_en", {31'b0, imem_en}, 32'h0);
    chk("async_rst inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("async_rst inst", inst, NOP);
    chk("async_rst inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; #1;
    chk("post_rst boot imem_addr", imem_addr, 32'h0000_2000);
    chk("post_rst boot imem_en", {31'b0, imem_en}, 32'h1);
    chk("post_rst boot inst_valid", {31'b0, inst_valid}, 32'h0);
    @(negedge clk); #1;
    chk("post_rst run inst_valid", {31'b0, inst_valid}, 32'h1);
    chk("post_rst run inst_pc", inst_pc, 32'h0000_2000);
    chk("post_rst run inst", inst, memf(32'h0000_2000));
    chk("post_rst run imem_addr", imem_addr, 32'h0000_2004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_2000, address of the first instruction fetched after reset.
REQ-002 Parameter: NOP_INST, default 32'h0000_0013, instruction word driven on inst whenever inst_valid=0.
REQ-003 Ports, in order: clk, in, 1, single clock; all state updates on rising edge.
REQ-004 rst_n, in, 1, asynchronous active-low reset.
REQ-005 pc_ctrl, in, 2, next-PC select from ControlUnit: 00 sequential, 01 reserved (treated as 00), 10 jalr target, 11 branch/jal target.
REQ-006 target, in, 32, redirect address, sampled only when pc_ctrl[1]=1.
REQ-007 stall, in, 1, freeze fetch and decode-side outputs.
REQ-008 imem_addr, out, 32, instruction memory word address for this cycle's fetch.
REQ-009 imem_en, out, 1, instruction memory read enable.
REQ-010 imem_rdata, in, 32, read data, valid exactly one cycle after imem_en=1 at imem_addr.
REQ-011 inst, out, 32, instruction presented to decode.
REQ-012 inst_pc, out, 32, PC of inst.
REQ-013 inst_valid, out, 1, inst is a real fetched instruction.
REQ-014 fetch_fault, out, 1, misaligned-target fault, sticky.
REQ-015 fault_pc, out, 32, offending effective target.

Function
REQ-016 States: BOOT, RUN, FLUSH, TRAP; BOOT entered on reset.
REQ-017 BOOT: imem_en=1, imem_addr=RESET_PC, inst_valid=0; next state RUN, fetch PC becomes RESET_PC+4.
REQ-018 RUN, stall=0, pc_ctrl[1]=0: inst=imem_rdata, inst_pc=PC issued the previous cycle, inst_valid=1; imem_addr advances by 4 each cycle.
REQ-019 Effective target = target with bit0 cleared for pc_ctrl=10, target unmodified for pc_ctrl=11.
REQ-020 Redirect (pc_ctrl[1]=1 in cycle N, effective target[1:0]=00): cycle N+1 imem_addr=effective target, state FLUSH, inst_valid=0 (word fetched in cycle N squashed); cycle N+2 inst=mem[target], inst_pc=target, inst_valid=1, state RUN.
REQ-021 Redirect priority over stall; stall ignored in the redirect cycle.
REQ-022 Redirect accepted in FLUSH; the latest redirect wins, FLUSH is re-entered.
REQ-023 Stall (stall=1, no redirect) in cycle N: imem_en=0, imem_addr, inst, inst_pc, inst_valid at N+1 identical to cycle N; the in-flight imem_rdata is captured in a hold register and presented after stall drops, with no instruction lost or duplicated.
REQ-024 Stall held for any number of cycles; release resumes sequence exactly where frozen.
REQ-025 Stall in BOOT or FLUSH: state held, inst_valid stays 0.
REQ-026 Misaligned effective target (bits[1:0]!=00): next cycle enter TRAP; fetch_fault=1, fault_pc=effective target, imem_en=0, inst_valid=0; held until reset; pc_ctrl and stall ignored.
REQ-027 Sequential PC arithmetic modulo 2^32: 32'hFFFF_FFFC+4=32'h0000_0000, no fault.
REQ-028 inst=NOP_INST whenever inst_valid=0.

Reset
REQ-029 rst_n=0 asynchronously forces: state BOOT, imem_addr=RESET_PC, imem_en=0, inst=NOP_INST, inst_pc=0, inst_valid=0, fetch_fault=0, fault_pc=0, hold register empty.
REQ-030 Reset mid-stall, mid-flush or in TRAP aborts immediately; the first cycle after release behaves per REQ-017.

Verification
REQ-031 Release reset, stall=0, pc_ctrl=00 -> imem_addr 0x2000, 0x2004, 0x2008; inst_valid 0,1,1; inst_pc 0x2000, 0x2004.
REQ-032 pc_ctrl=11, target=0x2100 in cycle N -> N+1 inst_valid=0, inst=0x00000013, imem_addr=0x2100; N+2 inst_pc=0x2100, inst_valid=1.
REQ-033 stall=1 for 3 cycles while inst_pc=0x2008 -> outputs frozen at 0x2008 for 3 cycles; after release inst_pc 0x200C, 0x2010, nothing skipped or repeated.
REQ-034 pc_ctrl=10, target=0x2201 -> effective 0x2200, no fault; pc_ctrl=11, target=0x2202 -> fetch_fault=1, fault_pc=0x2202, imem_en=0 until rst_n pulsed.
REQ-035 Redirect with stall=1 in the same cycle, then a second redirect during FLUSH -> first redirect taken, second target wins, only the second target's instruction ever has inst_valid=1.
REQ-036 Fetch at 0xFFFF_FFFC sequential -> next imem_addr 0x0000_0000, fetch_fault=0.
